// File: rtl/input_conditioner.sv
// GPIO input conditioning: optional 2-flop synchronizer, per-pin glitch filter,
// edge detection with sticky status, and broadcast of the conditioned value to 4 cores.
`timescale 1ns/1ps
module input_conditioner #(
  parameter int FILTER_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_input,
  input  logic [31:0]         sync_bypass,
  input  logic [31:0]         filter_en,
  input  logic [FILTER_W-1:0] filter_threshold,
  input  logic [31:0]         edge_clear,
  output logic [3:0][31:0]    core_input,
  output logic [31:0]         rise_event,
  output logic [31:0]         fall_event,
  output logic [31:0]         edge_status
);

  localparam logic [FILTER_W-1:0] CNT_ONE = {{(FILTER_W-1){1'b0}}, 1'b1};

  logic [31:0]               sync1;
  logic [31:0]               sync2;
  logic [31:0]               synced;
  logic [31:0]               filt_q;
  logic [31:0][FILTER_W-1:0] cnt;
  logic [31:0]               pin_value;
  logic [31:0]               last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_input;
      sync2 <= sync1;
    end
  end

  // Bypassed pins take the raw pad combinationally.
  assign synced = (sync_bypass & gpio_input) | (~sync_bypass & sync2);

  // A disabled filter tracks its input so that enabling it never creates an edge.
  // The counter only increments while below the threshold, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (!filter_en[i]) begin
          filt_q[i] <= synced[i];
          cnt[i]    <= '0;
        end else if (synced[i] == filt_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= filter_threshold) begin
          filt_q[i] <= synced[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign pin_value  = (filter_en & filt_q) | (~filter_en & synced);
  assign core_input = {4{pin_value}};
  assign rise_event = pin_value & ~last_q;
  assign fall_event = ~pin_value & last_q;

  // New edges take priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      edge_status <= '0;
    end else begin
      last_q      <= pin_value;
      edge_status <= (edge_status & ~edge_clear) | rise_event | fall_event;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: per-cycle vector table plus hand-built
// sequences for filter restart and asynchronous reset mid-count.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam logic [31:0] P0 = 32'h0000_0001;
  localparam logic [31:0] P3 = 32'h0000_0008;
  localparam logic [31:0] P5 = 32'h0000_0020;
  localparam logic [31:0] PH = 32'h0000_0F00;

  typedef struct {
    logic [31:0] gpio;
    logic [31:0] byp;
    logic [31:0] fen;
    logic [31:0] clr;
    logic [3:0]  thr;
    bit          no_clk;
    logic [31:0] e_core;
    logic [31:0] e_rise;
    logic [31:0] e_fall;
    logic [31:0] e_stat;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     gpio_input;
  logic [31:0]     sync_bypass;
  logic [31:0]     filter_en;
  logic [3:0]      filter_threshold;
  logic [31:0]     edge_clear;
  logic [3:0][31:0] core_input;
  logic [31:0]     rise_event;
  logic [31:0]     fall_event;
  logic [31:0]     edge_status;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [127:0] exp_q[$];
  vec_t        vecs[$];

  input_conditioner #(.FILTER_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .gpio_input       (gpio_input),
    .sync_bypass      (sync_bypass),
    .filter_en        (filter_en),
    .filter_threshold (filter_threshold),
    .edge_clear       (edge_clear),
    .core_input       (core_input),
    .rise_event       (rise_event),
    .fall_event       (fall_event),
    .edge_status      (edge_status)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic apply(input vec_t v);
    gpio_input       = v.gpio;
    sync_bypass      = v.byp;
    filter_en        = v.fen;
    edge_clear       = v.clr;
    filter_threshold = v.thr;
    exp_q.push_back({v.e_core, v.e_rise, v.e_fall, v.e_stat});
  endtask

  task automatic sample(input string name);
    logic [127:0] e;
    logic [127:0] got;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got no expectation required one", name);
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 4; c++) begin
      got = {core_input[c], rise_event, fall_event, edge_status};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s core%0d: {core,rise,fall,status} got %h required %h", name, c, got, e);
      end
    end
  endtask

  task automatic step_and_sample(input string name);
    @(posedge clk);
    #1;
    sample(name);
  endtask

  function automatic void add(input logic [31:0] g, input logic [31:0] b, input logic [31:0] f,
                              input logic [31:0] c, input bit nc, input logic [31:0] ec,
                              input logic [31:0] er, input logic [31:0] ef, input logic [31:0] es);
    vecs.push_back('{g, b, f, c, 4'd3, nc, ec, er, ef, es});
  endfunction

  initial begin
    vec_t v;

    // Sync path on pin 5, then coincident fall + clear (set wins), then clear alone
    add(P5, 0, 0, 0,  0, 0,  0,  0,  0);
    add(P5, 0, 0, 0,  0, P5, P5, 0,  0);
    add(P5, 0, 0, 0,  0, P5, 0,  0,  P5);
    add(0,  0, 0, 0,  0, P5, 0,  0,  P5);
    add(0,  0, 0, 0,  0, 0,  0,  P5, P5);
    add(0,  0, 0, P5, 0, 0,  0,  0,  P5);
    add(0,  0, 0, P5, 0, 0,  0,  0,  0);
    add(0,  0, 0, 0,  0, 0,  0,  0,  0);
    // Bypass on pin 0: combinational value and pulse before the edge
    add(P0, P0, 0, 0,  1, P0, P0, 0,  0);
    add(P0, P0, 0, 0,  0, P0, 0,  0,  P0);
    add(0,  P0, 0, 0,  1, 0,  0,  P0, P0);
    add(0,  P0, 0, P0, 0, 0,  0,  0,  P0);
    add(0,  P0, 0, P0, 0, 0,  0,  0,  0);
    // Filter on pin 3, threshold 3: 3-cycle glitch rejected
    for (int k = 0; k < 7; k++) add((k < 3) ? P3 : 32'h0, 0, P3, 0, 0, 0, 0, 0, 0);
    // 4-cycle high accepted, then 6-cycle low accepted, then clear
    for (int k = 0; k < 5; k++) add((k < 4) ? P3 : 32'h0, 0, P3, 0, 0, 0, 0, 0, 0);
    add(0, 0, P3, 0,  0, P3, P3, 0,  0);
    add(0, 0, P3, 0,  0, P3, 0,  0,  P3);
    add(0, 0, P3, 0,  0, P3, 0,  0,  P3);
    add(0, 0, P3, 0,  0, P3, 0,  0,  P3);
    add(0, 0, P3, 0,  0, 0,  0,  P3, P3);
    add(0, 0, P3, 0,  0, 0,  0,  0,  P3);
    add(0, 0, P3, P3, 0, 0,  0,  0,  0);

    // Reset state
    rst = 1'b1;
    v = '{0, 0, 0, 0, 4'd3, 1'b0, 0, 0, 0, 0};
    apply(v);
    repeat (2) @(posedge clk);
    #1;
    sample("reset_zero");
    // Bypassed pin follows the pad during reset and shows a rise
    v = '{P0, P0, 0, 0, 4'd3, 1'b1, P0, P0, 0, 0};
    apply(v);
    #1;
    sample("reset_bypass");
    v = '{0, 0, 0, 0, 4'd3, 1'b1, 0, 0, 0, 0};
    apply(v);
    #1;
    sample("reset_bypass_off");
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      if (vecs[i].no_clk) begin
        #1;
        sample($sformatf("vec%0d", i));
      end else begin
        step_and_sample($sformatf("vec%0d", i));
      end
    end

    // Filter restart: high 3, low 1, high thereafter; single rise on cycle 10
    for (int k = 1; k <= 12; k++) begin
      v = '{(k == 4) ? 32'h0 : P3, 0, P3, 0, 4'd3, 1'b0,
            (k >= 10) ? P3 : 32'h0, (k == 10) ? P3 : 32'h0, 32'h0, (k >= 11) ? P3 : 32'h0};
      apply(v);
      step_and_sample($sformatf("restart_k%0d", k));
    end

    // Async reset mid-count: pin 3 starts counting toward 0, pins 8-11 high
    gpio_input = PH;
    repeat (4) @(posedge clk);
    #2;
    gpio_input = PH | P3;
    rst = 1'b1;
    exp_q.push_back(128'h0);
    #1;
    sample("async_reset_no_edge");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      v = '{PH | P3, 0, P3, 0, 4'd3, 1'b0,
            (k >= 6) ? (PH | P3) : ((k >= 2) ? PH : 32'h0),
            (k == 2) ? PH : ((k == 6) ? P3 : 32'h0),
            32'h0,
            (k >= 7) ? (PH | P3) : ((k >= 3) ? PH : 32'h0)};
      apply(v);
      step_and_sample($sformatf("post_reset_k%0d", k));
    end

    // Final report
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter FILTER_W, default 4, width of the per-pin glitch-filter counter and of filter_threshold.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 gpio_input  input  32  raw pad inputs, asynchronous to clk.
REQ-005 sync_bypass  input  32  per-pin: 1 = skip the 2-flop synchronizer.
REQ-006 filter_en  input  32  per-pin: 1 = glitch filter active.
REQ-007 filter_threshold  input  FILTER_W  shared filter stability count.
REQ-008 edge_clear  input  32  per-pin: clear sticky edge status.
REQ-009 core_input  output  32 x [3:0] (indexed [core][bit])  conditioned pin value, broadcast identically to all 4 cores.
REQ-010 rise_event  output  32  per-pin 1-cycle pulse on a 0->1 transition of the conditioned value.
REQ-011 fall_event  output  32  per-pin 1-cycle pulse on a 1->0 transition of the conditioned value.
REQ-012 edge_status  output  32  per-pin sticky flag, set by any edge event.

Function
REQ-013 Per pin: sync1 <= gpio_input, sync2 <= sync1 each cycle.
REQ-014 synced[i] = sync_bypass[i] ? gpio_input[i] (combinational) : sync2[i].
REQ-015 Filter state per pin: filt_q (1 bit) and cnt (FILTER_W bits).
REQ-016 filter_en[i]=0: filt_q <= synced[i], cnt <= 0 each cycle (tracks, so enabling causes no spurious edge).
REQ-017 filter_en[i]=1 and synced[i]==filt_q: cnt <= 0, filt_q holds.
REQ-018 filter_en[i]=1, synced[i]!=filt_q, cnt<filter_threshold: cnt <= cnt+1, filt_q holds.
REQ-019 filter_en[i]=1, synced[i]!=filt_q, cnt>=filter_threshold: filt_q <= synced[i], cnt <= 0; new value requires filter_threshold+1 consecutive differing cycles.
REQ-020 A single cycle of agreement mid-count restarts the count from 0; cnt never wraps.
REQ-021 pin_value[i] = filter_en[i] ? filt_q[i] : synced[i]; core_input[c][i] = pin_value[i] for c = 0..3.
REQ-022 Latency gpio_input -> core_input: filter off, sync on = 2 edges; filter off, bypass = 0 (combinational); filter on adds filter_threshold+1 edges.
REQ-023 last_q <= pin_value each cycle.
REQ-024 rise_event = pin_value & ~last_q; fall_event = ~pin_value & last_q; each is high for exactly one cycle per transition.
REQ-025 edge_status[i] <= 1 when rise_event[i] or fall_event[i]; else 0 when edge_clear[i]; else holds.
REQ-026 Simultaneous edge and edge_clear on the same pin: set wins, status stays 1.
REQ-027 Changing filter_threshold mid-count takes effect immediately against the current cnt.
REQ-028 Toggling sync_bypass may produce a real edge event; this is intended, not filtered.

Reset
REQ-029 On rst assertion, immediately: sync1, sync2, filt_q, cnt, last_q, edge_status = 0.
REQ-030 During reset, outputs reflect zeroed state: core_input 0 (bypassed unfiltered pins follow gpio_input), events 0 except bypassed pins driven high.
REQ-031 Reset mid-filter-count discards the count; after release, counting restarts from 0.
REQ-032 A pin high at reset release produces one rise_event once the value propagates.

Verification
REQ-033 Sync path: pin 5 bypass=0, filter=0, gpio 0->1 between edges -> core_input[*][5]=1 after 2nd edge; rise_event[5] high 1 cycle; edge_status[5]=1.
REQ-034 Bypass: pin 0 bypass=1, gpio 0->1 -> core_input[*][0]=1 same cycle; rise_event[0] pulses until next edge.
REQ-035 Filter: pin 3 filter_en=1, threshold=3, 3-cycle high glitch -> no change, no event; 4-cycle high -> filt_q=1 on 4th edge after sync, single rise_event.
REQ-036 Restart: threshold=3, pattern high 3 cycles, low 1, high 4 -> exactly one rise, 4 cycles after the low cycle ends.
REQ-037 Sticky: edge_status[7]=1, edge_clear[7]=1 coincident with fall_event[7] -> stays 1; next cycle clear alone -> 0.
REQ-038 Async reset: assert rst mid-count with pins high -> all registers 0 without a clock edge; after release, rise_event per pin after 2 edges.
